fir_controller: RTL and testbench

- Sequencing FSM for the FIR DataPath (shift-register taps, CoefMem, multiplier, accumulator register, tap-address counter).
- Accepts one input sample per valid/ready handshake and shifts it into the tap chain.
- Clears the accumulator, then runs COEFNUM multiply-accumulate beats and presents the result under a valid/ready handshake.
- Cross-checks the datapath counter carry against its own beat counter and flags a sticky error on mismatch.

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_beat_counter.sv | 27 ++
 rtl/fir_controller.sv | 128 ++++++++++++
 tb/tb_fir_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR controller and its datapath: state encoding
// and the default tap-count parameters.
package fir_pkg;

    localparam int COEFNUM_DEFAULT    = 64;
    localparam int LOGCOEFNUM_DEFAULT = 6;
    localparam int SCNTW_DEFAULT      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } fir_state_t;

endpackage

// File: rtl/fir_beat_counter.sv
// Beat counter for the accumulate phase: enable, synchronous clear and a
// terminal-count flag; wraps naturally through its full binary range.
module fir_beat_counter #(
    parameter int               WIDTH    = 6,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/fir_controller.sv
// Sequencing FSM for the FIR datapath: sample handshake, COEFNUM MAC beats,
// result handshake, and a sticky cross-check of the datapath counter carry.
module fir_controller
    import fir_pkg::*;
#(
    parameter int COEFNUM    = COEFNUM_DEFAULT,
    parameter int LOGCOEFNUM = LOGCOEFNUM_DEFAULT,
    parameter int SCNTW      = SCNTW_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_co,
    output logic             load,
    output logic             clr_res,
    output logic             loadres,
    output logic             cnt_en,
    output logic             busy,
    output logic             err,
    output logic [SCNTW-1:0] samples_done
);

    fir_state_t            state_q;
    fir_state_t            state_d;
    logic [LOGCOEFNUM-1:0] beat;
    logic                  beat_last;
    logic                  accept;
    logic                  deliver;
    logic                  carry_bad;
    logic                  in_ready_c;
    logic                  out_valid_c;
    logic                  loadres_c;
    logic                  cnt_en_c;
    logic                  busy_c;
    logic                  err_q;
    logic [SCNTW-1:0]      done_cnt_q;

    fir_beat_counter #(
        .WIDTH    (LOGCOEFNUM),
        .TERMINAL (LOGCOEFNUM'(COEFNUM - 1))
    ) u_beat (
        .clock (clock),
        .reset (reset),
        .clr   (accept),
        .en    (cnt_en_c),
        .count (beat),
        .tc    (beat_last)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        deliver     = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        loadres_c   = 1'b0;
        cnt_en_c    = 1'b0;
        busy_c      = 1'b0;
        carry_bad   = cnt_co;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                cnt_en_c  = 1'b1;
                loadres_c = 1'b1;
                busy_c    = 1'b1;
                // Termination follows our own beat count; the carry is only checked.
                carry_bad = (cnt_co != beat_last);
                if (beat_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                busy_c      = 1'b1;
                if (out_ready) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            if (carry_bad) begin
                err_q <= 1'b1;
            end
            if (deliver) begin
                done_cnt_q <= done_cnt_q + SCNTW'(1);
            end
        end
    end

    // Every output is held low while reset is asserted, even before the first edge.
    assign in_ready     = reset & in_ready_c;
    assign out_valid    = reset & out_valid_c;
    assign load         = reset & accept;
    assign clr_res      = reset & accept;
    assign loadres      = reset & loadres_c;
    assign cnt_en       = reset & cnt_en_c;
    assign busy         = reset & busy_c;
    assign err          = reset & err_q;
    assign samples_done = reset ? done_cnt_q : '0;

endmodule

// File: tb/tb_fir_controller.sv
// Directed bench for fir_controller with COEFNUM=4; includes a small model of
// the datapath address counter that produces cnt_co.
module tb_fir_controller;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        cnt_co;
    logic        load;
    logic        clr_res;
    logic        loadres;
    logic        cnt_en;
    logic        busy;
    logic        err;
    logic [15:0] samples_done;

    logic [1:0]  adr;
    logic        co_force;

    int total = 0;
    int bad   = 0;

    // Output vector order: {in_ready,out_valid,load,clr_res,loadres,cnt_en,busy,err}
    localparam logic [7:0] V_ZERO   = 8'b0000_0000;
    localparam logic [7:0] V_IDLE   = 8'b1000_0000;
    localparam logic [7:0] V_ACCEPT = 8'b1011_0000;
    localparam logic [7:0] V_BEAT   = 8'b0000_1110;
    localparam logic [7:0] V_DONE   = 8'b0100_0010;

    fir_controller #(
        .COEFNUM    (4),
        .LOGCOEFNUM (2),
        .SCNTW      (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cnt_co       (cnt_co),
        .load         (load),
        .clr_res      (clr_res),
        .loadres      (loadres),
        .cnt_en       (cnt_en),
        .busy         (busy),
        .err          (err),
        .samples_done (samples_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        if (!reset) begin
            adr <= 2'd0;
        end else if (cnt_en) begin
            adr <= adr + 2'd1;
        end
    end

    assign cnt_co = (adr == 2'd3) | co_force;

    function automatic logic [7:0] outs();
        return {in_ready, out_valid, load, clr_res, loadres, cnt_en, busy, err};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        total++;
        if (outs() !== V_ZERO) begin
            bad++; $display("[TB] FAIL reset_outs got=%b exp=%b", outs(), V_ZERO);
        end
        total++;
        if (samples_done !== 16'd0) begin
            bad++; $display("[TB] FAIL reset_count got=%0d exp=0", samples_done);
        end
        reset = 1'b1;
        @(negedge clock);
        #1;
        total++;
        if (outs() !== V_IDLE) begin
            bad++; $display("[TB] FAIL reset_release got=%b exp=%b", outs(), V_IDLE);
        end
    endtask

    task automatic test_single();
        @(negedge clock);
        in_valid = 1'b1;
        #1;
        total++;
        if (outs() !== V_ACCEPT) begin
            bad++; $display("[TB] FAIL single_accept got=%b exp=%b", outs(), V_ACCEPT);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
            #1;
            total++;
            if (outs() !== V_BEAT) begin
                bad++; $display("[TB] FAIL single_beat%0d got=%b exp=%b", i, outs(), V_BEAT);
            end
        end
        @(negedge clock);
        out_ready = 1'b1;
        #1;
        total++;
        if (outs() !== V_DONE) begin
            bad++; $display("[TB] FAIL single_done got=%b exp=%b", outs(), V_DONE);
        end
        @(negedge clock);
        out_ready = 1'b0;
        #1;
        total++;
        if (outs() !== V_IDLE || samples_done !== 16'd1) begin
            bad++; $display("[TB] FAIL single_after got=%b/%0d exp=%b/1", outs(), samples_done, V_IDLE);
        end
    endtask

    task automatic test_back_pressure();
        @(negedge clock);
        in_valid = 1'b1;
        #1;
        total++;
        if (outs() !== V_ACCEPT) begin
            bad++; $display("[TB] FAIL bp_accept got=%b exp=%b", outs(), V_ACCEPT);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            total++;
            if (outs() !== V_BEAT) begin
                bad++; $display("[TB] FAIL bp_beat%0d got=%b exp=%b", i, outs(), V_BEAT);
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            total++;
            if (outs() !== V_DONE || samples_done !== 16'd1) begin
                bad++; $display("[TB] FAIL bp_hold%0d got=%b/%0d exp=%b/1", i, outs(), samples_done, V_DONE);
            end
        end
        @(negedge clock);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
        #1;
        total++;
        if (outs() !== V_IDLE || samples_done !== 16'd2) begin
            bad++; $display("[TB] FAIL bp_release got=%b/%0d exp=%b/2", outs(), samples_done, V_IDLE);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] exp_v;
        int         loads;
        loads = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (k == 0) begin
                in_valid  = 1'b1;
                out_ready = 1'b1;
            end
            #1;
            case (k % 6)
                0:       exp_v = V_ACCEPT;
                5:       exp_v = V_DONE;
                default: exp_v = V_BEAT;
            endcase
            if (load) loads++;
            total++;
            if (outs() !== exp_v) begin
                bad++; $display("[TB] FAIL stream_cyc%0d got=%b exp=%b", k, outs(), exp_v);
            end
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        total++;
        if (outs() !== V_IDLE || samples_done !== 16'd7 || loads != 5) begin
            bad++; $display("[TB] FAIL stream_end got=%b/%0d/%0d exp=%b/7/5", outs(), samples_done, loads, V_IDLE);
        end
    endtask

    task automatic test_carry_mismatch();
        @(negedge clock);
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        co_force = 1'b1;
        #1;
        total++;
        if (outs() !== V_BEAT) begin
            bad++; $display("[TB] FAIL carry_beat1 got=%b exp=%b", outs(), V_BEAT);
        end
        for (int i = 2; i < 4; i++) begin
            @(negedge clock);
            co_force = 1'b0;
            #1;
            total++;
            if (outs() !== (V_BEAT | 8'd1)) begin
                bad++; $display("[TB] FAIL carry_beat%0d got=%b exp=%b", i, outs(), V_BEAT | 8'd1);
            end
        end
        @(negedge clock);
        out_ready = 1'b1;
        #1;
        total++;
        if (outs() !== (V_DONE | 8'd1)) begin
            bad++; $display("[TB] FAIL carry_done got=%b exp=%b", outs(), V_DONE | 8'd1);
        end
        @(negedge clock);
        out_ready = 1'b0;
        #1;
        total++;
        if (outs() !== (V_IDLE | 8'd1) || samples_done !== 16'd8) begin
            bad++; $display("[TB] FAIL carry_sticky got=%b/%0d exp=%b/8", outs(), samples_done, V_IDLE | 8'd1);
        end
    endtask

    task automatic test_reset_mid_accum();
        @(negedge clock);
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (outs() !== V_ZERO || samples_done !== 16'd0) begin
            bad++; $display("[TB] FAIL midrst_assert got=%b/%0d exp=%b/0", outs(), samples_done, V_ZERO);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++;
        if (outs() !== V_IDLE || samples_done !== 16'd0) begin
            bad++; $display("[TB] FAIL midrst_release got=%b/%0d exp=%b/0", outs(), samples_done, V_IDLE);
        end
        @(negedge clock);
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        #1;
        total++;
        if (outs() !== V_DONE) begin
            bad++; $display("[TB] FAIL midrst_rerun got=%b exp=%b", outs(), V_DONE);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        #1;
        total++;
        if (outs() !== V_IDLE || samples_done !== 16'd1) begin
            bad++; $display("[TB] FAIL midrst_after got=%b/%0d exp=%b/1", outs(), samples_done, V_IDLE);
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        co_force  = 1'b0;
        test_reset();
        test_single();
        test_back_pressure();
        test_streaming();
        test_carry_mismatch();
        test_reset_mid_accum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
